// File: rtl/fetch_stage_pkg.sv
// Shared types for the instruction-fetch stage: FSM state, default NOP, IF/ID record.
package fetch_stage_pkg;

  typedef enum logic [1:0] {
    REQ  = 2'd0,
    WAIT = 2'd1,
    HOLD = 2'd2
  } fetch_state_t;

  localparam logic [31:0] NOP_INSTR = 32'h0000_0013;

  typedef struct packed {
    logic        valid;
    logic [31:0] instr;
    logic [31:0] pc;
  } if_id_type;

endpackage

// File: rtl/fetch_stage_pc_gen.sv
// PC register with +4 advance and redirect selection (jalr beats branch).
// FETCH_MISALIGN_CHECK_EN: word-align redirect targets and flag misaligned ones.
module fetch_stage_pc_gen #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        advance,
  input  logic        branch_taken,
  input  logic [31:0] branch_target,
  input  logic        jalr_flag,
  input  logic [31:0] jalr_target,
`ifdef FETCH_MISALIGN_CHECK_EN
  output logic        o_misaligned,
`endif
  output logic [31:0] o_pc
);

  logic        w_redirect;
  logic [31:0] w_raw_target;
  logic [31:0] w_target;
  logic [31:0] r_pc;

  assign w_redirect   = jalr_flag | branch_taken;
  assign w_raw_target = jalr_flag ? jalr_target : branch_target;

  always_comb begin
    w_target = w_raw_target;
`ifdef FETCH_MISALIGN_CHECK_EN
    w_target[1:0] = 2'b00;
`endif
  end

  // Redirect outranks the sequential advance; the add wraps naturally at 32 bits.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_pc <= RESET_PC;
    end else if (w_redirect) begin
      r_pc <= w_target;
    end else if (advance) begin
      r_pc <= r_pc + 32'd4;
    end
  end

`ifdef FETCH_MISALIGN_CHECK_EN
  logic r_misaligned;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_misaligned <= 1'b0;
    end else begin
      r_misaligned <= w_redirect & (|w_raw_target[1:0]);
    end
  end

  assign o_misaligned = r_misaligned;
`endif

  assign o_pc = r_pc;

endmodule

// File: rtl/fetch_stage.sv
// Instruction-fetch stage: single-outstanding imem requests, IF/ID register, stall skid, redirect drop.
// FETCH_MISALIGN_CHECK_EN adds the fetch_misaligned pulse output.
module fetch_stage
  import fetch_stage_pkg::*;
#(
  parameter logic [31:0] RESET_PC  = 32'h0000_0000,
  parameter logic [31:0] NOP_INSTR = 32'h0000_0013
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         stall,
  input  logic         branch_taken,
  input  logic [31:0]  branch_target,
  input  logic         jalr_flag,
  input  logic [31:0]  jalr_target,
  output logic         imem_req_valid,
  input  logic         imem_req_ready,
  output logic [31:0]  imem_req_addr,
  input  logic         imem_rsp_valid,
  input  logic [31:0]  imem_rsp_data,
  output logic         if_valid,
  output logic [31:0]  if_instr,
  output logic [31:0]  if_pc,
`ifdef FETCH_MISALIGN_CHECK_EN
  output logic         fetch_misaligned,
`endif
  output fetch_state_t o_dbg_state
);

  fetch_state_t r_state;
  logic         r_drop;
  if_id_type    r_if_id;
  logic [31:0]  r_skid;
  logic         w_redirect;
  logic         w_advance;
  logic [31:0]  w_pc;

  assign w_redirect = jalr_flag | branch_taken;
  assign w_advance  = !w_redirect && !stall &&
                      ((r_state == WAIT && imem_rsp_valid && !r_drop) || r_state == HOLD);

  fetch_stage_pc_gen #(
    .RESET_PC(RESET_PC)
  ) u_pc_gen (
    .clk          (clk),
    .reset        (reset),
    .advance      (w_advance),
    .branch_taken (branch_taken),
    .branch_target(branch_target),
    .jalr_flag    (jalr_flag),
    .jalr_target  (jalr_target),
`ifdef FETCH_MISALIGN_CHECK_EN
    .o_misaligned (fetch_misaligned),
`endif
    .o_pc         (w_pc)
  );

  // Request transfers on a cycle with imem_req_valid && imem_req_ready; valid stays
  // high and addr stable in REQ until accepted. Exactly one response per transfer.
  assign imem_req_valid = (r_state == REQ) && !reset;
  assign imem_req_addr  = w_pc;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= REQ;
      r_drop  <= 1'b0;
      r_if_id <= '{valid: 1'b0, instr: NOP_INSTR, pc: RESET_PC};
      r_skid  <= NOP_INSTR;
    end else if (w_redirect) begin
      r_if_id.valid <= 1'b0;
      r_if_id.instr <= NOP_INSTR;
      r_skid        <= NOP_INSTR;
      // A response is still owed for the old address: swallow it before refetching.
      if ((r_state == WAIT && !imem_rsp_valid) || (r_state == REQ && imem_req_ready)) begin
        r_drop  <= 1'b1;
        r_state <= WAIT;
      end else begin
        r_drop  <= 1'b0;
        r_state <= REQ;
      end
    end else begin
      if (!stall) begin
        r_if_id.valid <= 1'b0;
        r_if_id.instr <= NOP_INSTR;
      end
      case (r_state)
        REQ: begin
          if (imem_req_ready) r_state <= WAIT;
        end
        WAIT: begin
          if (imem_rsp_valid) begin
            if (r_drop) begin
              r_drop  <= 1'b0;
              r_state <= REQ;
            end else if (!stall) begin
              r_if_id <= '{valid: 1'b1, instr: imem_rsp_data, pc: w_pc};
              r_state <= REQ;
            end else begin
              r_skid  <= imem_rsp_data;
              r_state <= HOLD;
            end
          end
        end
        HOLD: begin
          if (!stall) begin
            r_if_id <= '{valid: 1'b1, instr: r_skid, pc: w_pc};
            r_skid  <= NOP_INSTR;
            r_state <= REQ;
          end
        end
        default: r_state <= REQ;
      endcase
    end
  end

  assign if_valid    = r_if_id.valid;
  assign if_instr    = r_if_id.instr;
  assign if_pc       = r_if_id.pc;
  assign o_dbg_state = r_state;

endmodule
